// File: rtl/tpg_pkg.sv
// Shared types and constants for the test-pattern / video-timing generator.
package tpg_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ACT  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } axis_state_e;

  typedef enum logic {
    CTRL_IDLE = 1'b0,
    CTRL_RUN  = 1'b1
  } ctrl_state_e;

  // {R,G,B} lane enables: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

endpackage

// File: rtl/tpg_axis_counter.sv
// One raster axis: absolute position plus an ACTIVE/FP/SYNC/BP region FSM
// advanced by a region-local counter.
module tpg_axis_counter
  import tpg_pkg::*;
#(
  parameter int CNT_BITS = 12,
  parameter int ACT_LEN  = 1920,
  parameter int FP_LEN   = 88,
  parameter int SYNC_LEN = 44,
  parameter int BP_LEN   = 148
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                step_i,
  input  logic                clear_i,
  output logic [CNT_BITS-1:0] count_o,
  output axis_state_e         state_o,
  output logic                wrap_o
);

  axis_state_e         state_q;
  axis_state_e         followState;
  logic [CNT_BITS-1:0] count_q;
  logic [CNT_BITS-1:0] local_q;
  logic [CNT_BITS-1:0] regionLast;

  always_comb begin
    regionLast  = CNT_BITS'(ACT_LEN - 1);
    followState = FP;
    unique case (state_q)
      ACT: begin
        regionLast  = CNT_BITS'(ACT_LEN - 1);
        followState = FP;
      end
      FP: begin
        regionLast  = CNT_BITS'(FP_LEN - 1);
        followState = SYNC;
      end
      SYNC: begin
        regionLast  = CNT_BITS'(SYNC_LEN - 1);
        followState = BP;
      end
      BP: begin
        regionLast  = CNT_BITS'(BP_LEN - 1);
        followState = ACT;
      end
    endcase
  end

  // Last position of the axis; the caller qualifies it with its own step.
  assign wrap_o = (state_q == BP) && (local_q == regionLast);

  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      state_q <= ACT;
      local_q <= '0;
      count_q <= '0;
    end else if (step_i) begin
      if (local_q == regionLast) begin
        state_q <= followState;
        local_q <= '0;
      end else begin
        local_q <= local_q + 1'b1;
      end
      count_q <= wrap_o ? '0 : count_q + 1'b1;
    end
  end

  assign count_o = count_q;
  assign state_o = state_q;

endmodule

// File: rtl/tpg_timing_gen.sv
// Test-pattern and video-timing generator producing a registered vs/hs/de/data raster.
// Optional border overlay (all-ones ring on the active edge pixels) under `TPG_BORDER_EN.
module tpg_timing_gen
  import tpg_pkg::*;
#(
  parameter int   DATA_WIDTH = 24,
  parameter int   CNT_BITS   = 12,
  parameter int   H_ACTIVE   = 1920,
  parameter int   H_FP       = 88,
  parameter int   H_SYNC     = 44,
  parameter int   H_BP       = 148,
  parameter int   V_ACTIVE   = 1080,
  parameter int   V_FP       = 4,
  parameter int   V_SYNC     = 5,
  parameter int   V_BP       = 36,
  parameter logic HS_POL     = 1'b1,
  parameter logic VS_POL     = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [1:0]            pattern_i,
  input  logic [DATA_WIDTH-1:0] color_i,
  output logic                  vs_o,
  output logic                  hs_o,
  output logic                  de_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  frame_start_o
);

  localparam int BW    = H_ACTIVE / 8;
  localparam int LANES = DATA_WIDTH / 8;

  ctrl_state_e           ctrl_q;
  pattern_e              pattern_q;
  logic [DATA_WIDTH-1:0] color_q;
  logic                  de_q;
  logic                  hs_q;
  logic                  vs_q;
  logic                  fs_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [CNT_BITS-1:0]   hc;
  logic [CNT_BITS-1:0]   vc;
  axis_state_e           hState;
  axis_state_e           vState;
  logic                  hWrap;
  logic                  vWrap;
  logic                  running;
  logic                  active;
  logic                  frameWrap;
  logic [2:0]            barIdx;
  logic [2:0]            barRgb;
  logic [DATA_WIDTH-1:0] barPix;
  logic [DATA_WIDTH-1:0] pixel;

  assign running   = (ctrl_q == CTRL_RUN);
  assign active    = (hState == ACT) && (vState == ACT);
  assign frameWrap = hWrap && vWrap;

  tpg_axis_counter #(
    .CNT_BITS (CNT_BITS),
    .ACT_LEN  (H_ACTIVE),
    .FP_LEN   (H_FP),
    .SYNC_LEN (H_SYNC),
    .BP_LEN   (H_BP)
  ) u_hcount (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .step_i  (running),
    .clear_i (!running),
    .count_o (hc),
    .state_o (hState),
    .wrap_o  (hWrap)
  );

  tpg_axis_counter #(
    .CNT_BITS (CNT_BITS),
    .ACT_LEN  (V_ACTIVE),
    .FP_LEN   (V_FP),
    .SYNC_LEN (V_SYNC),
    .BP_LEN   (V_BP)
  ) u_vcount (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .step_i  (running && hWrap),
    .clear_i (!running),
    .count_o (vc),
    .state_o (vState),
    .wrap_o  (vWrap)
  );

  // Bar index from a descending comparator chain so the lowest matching bar wins.
  always_comb begin
    barIdx = 3'd7;
    for (int k = 7; k >= 0; k--) begin
      if (hc < CNT_BITS'((k + 1) * BW)) barIdx = 3'(k);
    end
    barRgb = BAR_RGB[barIdx];
    barPix = '0;
    for (int l = 0; l < LANES; l++) begin
      barPix[l*8 +: 8] = {8{barRgb[l % 3]}};
    end

    pixel = '0;
    unique case (pattern_q)
      PAT_BARS:  pixel = barPix;
      PAT_RAMP:  pixel = {LANES{hc[7:0]}};
      PAT_CHECK: pixel = {DATA_WIDTH{hc[5] ^ vc[5]}};
      PAT_SOLID: pixel = color_q;
    endcase
`ifdef TPG_BORDER_EN
    if (hc == '0 || hc == CNT_BITS'(H_ACTIVE - 1) ||
        vc == '0 || vc == CNT_BITS'(V_ACTIVE - 1)) begin
      pixel = '1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ctrl_q    <= CTRL_IDLE;
      pattern_q <= PAT_BARS;
      color_q   <= '0;
      de_q      <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      fs_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      de_q   <= 1'b0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      fs_q   <= 1'b0;
      data_q <= '0;
      unique case (ctrl_q)
        CTRL_IDLE: begin
          if (en_i) begin
            ctrl_q    <= CTRL_RUN;
            pattern_q <= pattern_e'(pattern_i);
            color_q   <= color_i;
          end
        end
        CTRL_RUN: begin
          de_q   <= active;
          hs_q   <= (hState == SYNC) ? HS_POL : ~HS_POL;
          vs_q   <= (vState == SYNC) ? VS_POL : ~VS_POL;
          fs_q   <= (hc == '0) && (vc == '0);
          data_q <= active ? pixel : '0;
          // Enable only matters at the frame wrap, so frames are never cut short.
          if (frameWrap) begin
            if (en_i) begin
              pattern_q <= pattern_e'(pattern_i);
              color_q   <= color_i;
            end else begin
              ctrl_q <= CTRL_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign de_o          = de_q;
  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign frame_start_o = fs_q;
  assign data_o        = data_q;

endmodule

// File: tb/tb_tpg_timing_gen.sv
// Directed bench for tpg_timing_gen on a reduced 22x11 raster (16x8 active).
module tb_tpg_timing_gen;

  localparam int HT = 22;
  localparam int VT = 11;
  localparam int FRAME = HT * VT;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [1:0]  pattern_i;
  logic [23:0] color_i;
  logic        vs_o;
  logic        hs_o;
  logic        de_o;
  logic [23:0] data_o;
  logic        frame_start_o;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] barsExp [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  tpg_timing_gen #(
    .DATA_WIDTH (24),
    .CNT_BITS   (12),
    .H_ACTIVE   (16),
    .H_FP       (2),
    .H_SYNC     (2),
    .H_BP       (2),
    .V_ACTIVE   (8),
    .V_FP       (1),
    .V_SYNC     (1),
    .V_BP       (1),
    .HS_POL     (1'b1),
    .VS_POL     (1'b1)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .pattern_i     (pattern_i),
    .color_i       (color_i),
    .vs_o          (vs_o),
    .hs_o          (hs_o),
    .de_o          (de_o),
    .data_o        (data_o),
    .frame_start_o (frame_start_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [23:0] ovl(input int x, input int y, input logic [23:0] v);
`ifdef TPG_BORDER_EN
    if (x == 0 || x == 15 || y == 0 || y == 7) return 24'hFFFFFF;
`endif
    return v;
  endfunction

  function automatic logic [27:0] expRaster(input int p, input logic [23:0] v);
    int  x;
    int  y;
    logic de;
    x  = p % HT;
    y  = p / HT;
    de = (x < 16) && (y < 8);
    return {de, (x == 18 || x == 19), (y == 9), (p == 0), de ? ovl(x, y, v) : 24'h0};
  endfunction

  task automatic test_reset();
    rst_i = 1'b0; en_i = 1'b0; pattern_i = 2'd0; color_i = 24'h0;
    repeat (3) tick();
    vectors++;
    if ({de_o, hs_o, vs_o, frame_start_o} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl got %b want 0000", {de_o, hs_o, vs_o, frame_start_o});
    end
    vectors++;
    if (data_o !== 24'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_data got %h want 000000", data_o);
    end
  endtask

  task automatic test_solid_frame();
    logic [27:0] obs;
    logic [27:0] ex;
    rst_i = 1'b1; en_i = 1'b1; pattern_i = 2'd3; color_i = 24'h123456;
    tick();
    vectors++;
    if (de_o !== 1'b0 || frame_start_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL first_edge got de=%b fs=%b want 0 0", de_o, frame_start_o);
    end
    tick();
    for (int p = 0; p < FRAME; p++) begin
      obs = {de_o, hs_o, vs_o, frame_start_o, data_o};
      ex  = expRaster(p, 24'h123456);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("[TB] FAIL solid_raster p=%0d got %h want %h", p, obs, ex);
      end
      tick();
    end
    vectors++;
    if (frame_start_o !== 1'b1 || de_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL next_frame_start got fs=%b de=%b want 1 1", frame_start_o, de_o);
    end
  endtask

  task automatic test_patterns();
    logic [23:0] ex;
    pattern_i = 2'd0;
    tick();
    vectors++;
    if (data_o !== ovl(1, 0, 24'h123456)) begin
      miscompares++;
      $display("[TB] FAIL midframe_hold got %h want %h", data_o, ovl(1, 0, 24'h123456));
    end
    repeat (FRAME - 1) tick();

    for (int pat = 0; pat < 3; pat++) begin
      vectors++;
      if (frame_start_o !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL pattern%0d_frame_start got %b want 1", pat, frame_start_o);
      end
      repeat (HT) tick();
      for (int x = 0; x < 16; x++) begin
        case (pat)
          0:       ex = ovl(x, 1, barsExp[x / 2]);
          1:       ex = ovl(x, 1, {3{8'(x)}});
          default: ex = ovl(x, 1, 24'h0);
        endcase
        vectors++;
        if (de_o !== 1'b1 || data_o !== ex) begin
          miscompares++;
          $display("[TB] FAIL pattern%0d_x%0d got de=%b %h want 1 %h", pat, x, de_o, data_o, ex);
        end
        if (x == 0) begin
          pattern_i = 2'(pat + 1);
          color_i   = 24'h0;
        end
        tick();
      end
      repeat (FRAME - HT - 16) tick();
    end
  endtask

  task automatic test_border_en_drop();
    logic [27:0] obs;
    logic [27:0] ex;
    for (int p = 0; p < FRAME; p++) begin
      obs = {de_o, hs_o, vs_o, frame_start_o, data_o};
      ex  = expRaster(p, 24'h0);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("[TB] FAIL border_raster p=%0d got %h want %h", p, obs, ex);
      end
      if (p == 50) en_i = 1'b0;
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      obs = {de_o, hs_o, vs_o, frame_start_o, data_o};
      vectors++;
      if (obs !== 28'h0) begin
        miscompares++;
        $display("[TB] FAIL idle_after_drop i=%0d got %h want 0", i, obs);
      end
      tick();
    end
  endtask

  task automatic test_reenable();
    en_i = 1'b1; pattern_i = 2'd3; color_i = 24'hABCDEF;
    tick();
    vectors++;
    if (frame_start_o !== 1'b0 || de_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL enable_edge got fs=%b de=%b want 0 0", frame_start_o, de_o);
    end
    tick();
    vectors++;
    if (frame_start_o !== 1'b1 || de_o !== 1'b1 || data_o !== ovl(0, 0, 24'hABCDEF)) begin
      miscompares++;
      $display("[TB] FAIL reenable_start got fs=%b de=%b %h want 1 1 %h",
               frame_start_o, de_o, data_o, ovl(0, 0, 24'hABCDEF));
    end
  endtask

  task automatic test_mid_reset();
    logic [27:0] obs;
    logic [27:0] ex;
    repeat (3 * HT + 5) tick();
    vectors++;
    if (de_o !== 1'b1 || data_o !== ovl(5, 3, 24'hABCDEF)) begin
      miscompares++;
      $display("[TB] FAIL pre_reset got de=%b %h want 1 %h", de_o, data_o, ovl(5, 3, 24'hABCDEF));
    end
    rst_i = 1'b0;
    tick();
    obs = {de_o, hs_o, vs_o, frame_start_o, data_o};
    vectors++;
    if (obs !== 28'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset got %h want 0", obs);
    end
    rst_i = 1'b1;
    tick();
    vectors++;
    if (de_o !== 1'b0 || frame_start_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL restart_edge got de=%b fs=%b want 0 0", de_o, frame_start_o);
    end
    tick();
    for (int p = 0; p < HT; p++) begin
      obs = {de_o, hs_o, vs_o, frame_start_o, data_o};
      ex  = expRaster(p, 24'hABCDEF);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("[TB] FAIL restart_line p=%0d got %h want %h", p, obs, ex);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_solid_frame();
    test_patterns();
    test_border_en_drop();
    test_reenable();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
